bidir_deser: RTL
================

// Module: bidir_deser
// PURPOSE
//  Serial-in, parallel-out receiver; the counterpart to the team's parallel-load bidirectional shift register.
//  Collects a strobed serial bit stream into WIDTH-bit words, MSB-first or LSB-first.
//  Presents each finished word through a one-entry valid/ready output buffer.
//  Sits between a serial link front end and word-wide downstream logic.
// PARAMETERS
//  WIDTH       4   word width in bits, >= 2
//  EVEN_PAR    1   parity sense when BIDIR_DESER_PARITY_EN is defined: 1 = even, 0 = odd
// PORTS
//  clk        in   1      rising-edge clock, the only clock
//  rst        in   1      synchronous, active-high reset
//  sin        in   1      serial data bit
//  sin_valid  in   1      sin is sampled on this edge; low = hold, no shift
//  dir        in   1      0 = left shift / MSB-first, 1 = right shift / LSB-first
//  out_data   out  WIDTH  assembled word; stable while out_valid=1
//  out_valid  out  1      word available
//  out_ready  in   1      downstream accepts the word when out_valid & out_ready
//  busy       out  1      partial word in progress (bit count != 0)
//  overrun    out  1      1-cycle pulse: a finished word was dropped
//  parity_err out  1      only with BIDIR_DESER_PARITY_EN; qualifies out_data
// BEHAVIOUR
//  - Reset (rst=1 at an edge): sr=0, cnt=0, state=IDLE, out_data=0, out_valid=0, busy=0, overrun=0, parity_err=0.
//  - Reset mid-word discards the partial word; reset with a word buffered discards that word.
//  - FSM IDLE -> SHIFT on the first sampled bit; SHIFT -> IDLE when bit WIDTH is sampled.
//  - With the macro defined: SHIFT -> PAR after bit WIDTH; PAR -> IDLE on the next sampled bit.
//  - dir is latched on the first bit of each word; dir changes mid-word are ignored until the next word.
//  - Left shift:  sr <= {sr[WIDTH-2:0], sin}  (first bit ends in MSB).
//  - Right shift: sr <= {sin, sr[WIDTH-1:1]}  (first bit ends in LSB).
//  - sin_valid=0: no shift, cnt unchanged, state unchanged; gaps of any length are allowed.
//  - Completion edge (the edge that samples the last data bit, or the parity bit):
//    - Buffer write is allowed when out_valid=0, or when out_valid & out_ready on that same edge.
//    - Allowed: out_data <= shifted word and out_valid <= 1 on that edge (0-cycle latency after the last bit).
//    - Not allowed: the word is dropped, overrun=1 for one cycle, and the buffered word is kept.
//  - out_valid & out_ready with no completion: out_valid <= 0; out_data holds its value.
//  - Back-to-back words with out_ready held at 1 sustain one word per WIDTH sampled bits without overrun.
//  - cnt has width $clog2(WIDTH+1); it wraps to 0 at completion.
// CONFIGURATION
//  BIDIR_DESER_PARITY_EN defined:
//    - One extra parity bit follows each word and is never shifted into sr.
//    - parity_err <= (^word ^ parity_bit) != ~EVEN_PAR[0]; it is written together with out_data.
//    - The word is delivered even when parity_err=1.
//  BIDIR_DESER_PARITY_EN undefined: no PAR state, no parity_err port, and EVEN_PAR is unused.
// STRUCTURE
//  Package bidir_deser_pkg holds:
//    - typedef enum logic {DIR_LEFT, DIR_RIGHT} dir_t
//    - typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_PAR} state_t
//  Sub-module deser_shift_core: sr, cnt, latched dir, and the next-word combinational value.
//  Top level: FSM, output buffer, overrun and parity logic.
// TESTING (WIDTH=4)
//  1. dir=0; bits 1,0,1,1 on consecutive edges
//     -> out_valid=1 on the 4th edge, out_data=4'b1011, held until out_ready=1.
//  2. dir=1; bits 1,0,1,1 -> out_data=4'b1101.
//     Toggling dir after bit 2 does not change the result.
//  3. Same bits as test 1 with 3 idle cycles (sin_valid=0) between each bit
//     -> out_data=4'b1011; busy=1 from bit 1 until completion.
//  4. out_ready=0; word 4'hA completes, then word 4'h5 completes
//     -> overrun pulses 1 cycle, out_data stays 4'hA.
//     With out_ready=1 the same stream yields 4'hA then 4'h5 with no overrun.
//  5. rst=1 after 2 bits, then bits 0,1,1,0 with dir=0
//     -> single word 4'b0110, no stale bits.
//  6. Macro defined, EVEN_PAR=1; data 1,0,1,1 plus parity bit 1 -> parity_err=0.
//     Parity bit 0 -> parity_err=1, out_data=4'b1011.

Source files
------------

// File: rtl/bidir_deser_pkg.sv
// -----------------------------------------------------------------------------
// bidir_deser_pkg
// Shared types and helpers for the bidir_deser serial-in/parallel-out receiver.
//   dir_t        : shift direction (left = MSB-first, right = LSB-first)
//   state_t      : receiver FSM states (ST_PAR only reachable when the
//                  BIDIR_DESER_PARITY_EN macro is defined)
//   parity_fault : parity check helper used by the top level
// -----------------------------------------------------------------------------
package bidir_deser_pkg;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PAR   = 2'd2
    } state_t;

    // word_xor is the XOR-reduction of the data word. With even parity the
    // word plus its parity bit must have an even number of ones (XOR = 0);
    // with odd parity the total XOR must be 1.
    function automatic logic parity_fault(input logic word_xor,
                                          input logic par_bit,
                                          input logic even_par);
        return ((word_xor ^ par_bit) != ~even_par);
    endfunction

endpackage

// File: rtl/bidir_deser_if.sv
// -----------------------------------------------------------------------------
// bidir_deser_if
// Bundles the serial input side and the word-wide output buffer of bidir_deser.
//   master : the environment (serial front end + downstream consumer)
//   slave  : the receiver itself
// Signals: sin, sin_valid, dir, out_ready (to receiver);
//          out_data[WIDTH], out_valid, busy, overrun (from receiver);
//          parity_err (from receiver, only with BIDIR_DESER_PARITY_EN).
// -----------------------------------------------------------------------------
interface bidir_deser_if #(
    parameter int WIDTH = 4
);
    logic             sin;
    logic             sin_valid;
    logic             dir;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             busy;
    logic             overrun;
`ifdef BIDIR_DESER_PARITY_EN
    logic             parity_err;
`endif

    modport master (
        output sin, sin_valid, dir, out_ready,
        input  out_data, out_valid, busy, overrun
`ifdef BIDIR_DESER_PARITY_EN
        , input parity_err
`endif
    );

    modport slave (
        input  sin, sin_valid, dir, out_ready,
        output out_data, out_valid, busy, overrun
`ifdef BIDIR_DESER_PARITY_EN
        , output parity_err
`endif
    );

endinterface

// File: rtl/bidir_deser_shift_core.sv
// -----------------------------------------------------------------------------
// deser_shift_core
// Shift register, bit counter and per-word direction latch for bidir_deser.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   shift_en   : sample sin into the shift register this edge
//   cnt_clr    : end of the parity slot, return the counter to 0
//   sin        : serial data bit
//   dir        : requested direction, only honoured on the first bit of a word
//   done_word  : word to deliver on the completion edge
//   last_bit   : this edge samples the final data bit of the word
//   busy       : registered, bit count != 0
// With PAR_EN=1 the counter parks at WIDTH after the last data bit so that the
// receiver still reads as busy while it waits for the parity bit, and the
// finished word is already sitting in sr.
// -----------------------------------------------------------------------------
module deser_shift_core
    import bidir_deser_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter bit PAR_EN = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic             cnt_clr,
    input  logic             sin,
    input  dir_t             dir,
    output logic [WIDTH-1:0] done_word,
    output logic             last_bit,
    output logic             busy
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] sr_r;
    logic [CNT_W-1:0] cnt_r;
    dir_t             dir_r;
    logic             busy_r;

    dir_t             dir_eff_s;
    logic [WIDTH-1:0] word_next_s;
    logic [CNT_W-1:0] cnt_next_s;
    logic             last_bit_s;

    // The first bit of a word takes the live dir; later bits use the latched one.
    assign dir_eff_s  = (cnt_r == {CNT_W{1'b0}}) ? dir : dir_r;
    assign last_bit_s = shift_en && (cnt_r == CNT_W'(WIDTH - 1));

    // Next shift-register value if sin is sampled this edge.
    always_comb begin
        word_next_s = sr_r;
        case (dir_eff_s)
            DIR_LEFT:  word_next_s = {sr_r[WIDTH-2:0], sin};
            DIR_RIGHT: word_next_s = {sin, sr_r[WIDTH-1:1]};
            default:   word_next_s = {sr_r[WIDTH-2:0], sin};
        endcase
    end

    // Bit counter: wraps at the last data bit, or parks at WIDTH for parity.
    always_comb begin
        cnt_next_s = cnt_r;
        if (shift_en) begin
            if (last_bit_s) begin
                cnt_next_s = PAR_EN ? CNT_W'(WIDTH) : {CNT_W{1'b0}};
            end else begin
                cnt_next_s = cnt_r + CNT_W'(1);
            end
        end else if (cnt_clr) begin
            cnt_next_s = {CNT_W{1'b0}};
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    // Shift register, counter, direction latch and busy flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_r   <= {WIDTH{1'b0}};
            cnt_r  <= {CNT_W{1'b0}};
            dir_r  <= DIR_LEFT;
            busy_r <= 1'b0;
        end else begin
            if (shift_en) begin
                sr_r <= word_next_s;
                if (cnt_r == {CNT_W{1'b0}}) begin
                    dir_r <= dir;
                end
            end
            cnt_r  <= cnt_next_s;
            busy_r <= (cnt_next_s != {CNT_W{1'b0}});
        end
    end

    assign done_word = PAR_EN ? sr_r : word_next_s;
    assign last_bit  = last_bit_s;
    assign busy      = busy_r;

endmodule

// File: rtl/bidir_deser.sv
// -----------------------------------------------------------------------------
// bidir_deser
// Serial-in, parallel-out receiver. Collects strobed serial bits into WIDTH-bit
// words (MSB-first when dir=0, LSB-first when dir=1) and hands each finished
// word to a one-entry valid/ready output buffer.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : bidir_deser_if.slave -- sin/sin_valid/dir in, out_data/out_valid/
//          out_ready buffer, busy, overrun pulse, parity_err (optional)
// Optional feature: define BIDIR_DESER_PARITY_EN to expect one parity bit after
// every word; EVEN_PAR selects even (1) or odd (0) parity. A word with a bad
// parity bit is still delivered, flagged by parity_err.
// -----------------------------------------------------------------------------
module bidir_deser
    import bidir_deser_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int EVEN_PAR = 1
) (
    input  logic          clk,
    input  logic          rst,
    bidir_deser_if.slave  bus
);
`ifdef BIDIR_DESER_PARITY_EN
    localparam bit PAR_EN_C = 1'b1;
`else
    localparam bit PAR_EN_C = 1'b0;
`endif

    state_t           state_r;
    logic [WIDTH-1:0] out_data_r;
    logic             out_valid_r;
    logic             overrun_r;
`ifdef BIDIR_DESER_PARITY_EN
    logic             parity_err_r;
`endif

    logic             shift_en_s;
    logic             cnt_clr_s;
    logic             complete_s;
    logic             can_write_s;
    logic [WIDTH-1:0] done_word_s;
    logic             last_bit_s;
    logic             busy_s;

    // The parity slot consumes a sampled bit without shifting it in.
    assign shift_en_s  = bus.sin_valid && (state_r != ST_PAR);
    assign cnt_clr_s   = bus.sin_valid && (state_r == ST_PAR);
`ifdef BIDIR_DESER_PARITY_EN
    assign complete_s  = cnt_clr_s;
`else
    assign complete_s  = last_bit_s;
`endif
    // The buffer frees up on the same edge it is read, so a word can land then.
    assign can_write_s = !out_valid_r || bus.out_ready;

    deser_shift_core #(
        .WIDTH  (WIDTH),
        .PAR_EN (PAR_EN_C)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .shift_en  (shift_en_s),
        .cnt_clr   (cnt_clr_s),
        .sin       (bus.sin),
        .dir       (dir_t'(bus.dir)),
        .done_word (done_word_s),
        .last_bit  (last_bit_s),
        .busy      (busy_s)
    );

    // FSM, output buffer, overrun pulse and parity flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            out_data_r   <= {WIDTH{1'b0}};
            out_valid_r  <= 1'b0;
            overrun_r    <= 1'b0;
`ifdef BIDIR_DESER_PARITY_EN
            parity_err_r <= 1'b0;
`endif
        end else begin
            overrun_r <= 1'b0;

            case (state_r)
                ST_IDLE: begin
                    if (bus.sin_valid) begin
                        state_r <= ST_SHIFT;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    if (last_bit_s) begin
                        state_r <= PAR_EN_C ? ST_PAR : ST_IDLE;
                    end else begin
                        state_r <= ST_SHIFT;
                    end
                end
                ST_PAR: begin
                    if (bus.sin_valid) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_PAR;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase

            if (complete_s) begin
                if (can_write_s) begin
                    out_data_r  <= done_word_s;
                    out_valid_r <= 1'b1;
`ifdef BIDIR_DESER_PARITY_EN
                    parity_err_r <= parity_fault(^done_word_s, bus.sin,
                                                 EVEN_PAR[0]);
`endif
                end else begin
                    // Buffered word wins; the new one is lost.
                    overrun_r <= 1'b1;
                end
            end else if (out_valid_r && bus.out_ready) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign bus.out_data   = out_data_r;
    assign bus.out_valid  = out_valid_r;
    assign bus.busy       = busy_s;
    assign bus.overrun    = overrun_r;
`ifdef BIDIR_DESER_PARITY_EN
    assign bus.parity_err = parity_err_r;
`endif

endmodule
